// File: rtl/sr_latch_pkg.sv
// Shared definitions for the registered gated SR latch: invalid-input policies,
// the decoded {S,R} command type and the error counter width.
package sr_latch_pkg;

  localparam int POL_NOR  = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;
  localparam int POL_HOLD = 3;

  localparam int ERR_CNT_W = 16;

  // Encoding matches the {S,R} bit pair so a plain cast decodes a command.
  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RESET   = 2'b01,
    SET     = 2'b10,
    INVALID = 2'b11
  } sr_cmd_e;

endpackage

// File: rtl/sr_latch_sync.sv
// sr_sync: DEPTH-deep, reset-clearable delay line for the S/R/E bundle.
// A depth of 0 gives a straight pass-through.
module sr_sync #(
  parameter int W     = 3,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sr_latch.sv
// Registered gated SR latch, WIDTH independent bits sharing one enable.
// Optional build macro SR_LATCH_ERR_CNT_EN adds a saturating err_cnt output.
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int INVALID_POLICY = 0,
  parameter int SYNC_STAGES    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     S,
  input  logic [WIDTH-1:0]     R,
  input  logic                 E,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     Q_not,
  output logic [WIDTH-1:0]     invalid
`ifdef SR_LATCH_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  generate
    if (INVALID_POLICY < 0 || INVALID_POLICY > 3) begin : g_bad_policy
      $error("sr_latch: INVALID_POLICY must be 0..3");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("sr_latch: SYNC_STAGES must be 0..3");
    end
  endgenerate

  logic [WIDTH-1:0] s_q, r_q;
  logic             e_q;

  sr_sync #(
    .W     (2*WIDTH + 1),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({E, S, R}),
    .q   ({e_q, s_q, r_q})
  );

  logic [WIDTH-1:0] q_r, both_low_r, invalid_r;
  logic [WIDTH-1:0] q_nxt, both_low_nxt, invalid_nxt;
  sr_cmd_e          cmd;

  // both_low is never carried over by default, so any non-invalid edge exits
  // the NOR state into reset (q is already 0 there).
  always_comb begin
    q_nxt        = q_r;
    both_low_nxt = '0;
    invalid_nxt  = '0;
    cmd          = HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      cmd = e_q ? sr_cmd_e'({s_q[i], r_q[i]}) : HOLD;
      case (cmd)
        RESET: q_nxt[i] = 1'b0;
        SET:   q_nxt[i] = 1'b1;
        INVALID: begin
          invalid_nxt[i] = 1'b1;
          if (INVALID_POLICY == POL_NOR) begin
            q_nxt[i]        = 1'b0;
            both_low_nxt[i] = 1'b1;
          end else if (INVALID_POLICY == POL_SET) begin
            q_nxt[i] = 1'b1;
          end else if (INVALID_POLICY == POL_RST) begin
            q_nxt[i] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r        <= '0;
      both_low_r <= '0;
      invalid_r  <= '0;
    end else begin
      q_r        <= q_nxt;
      both_low_r <= both_low_nxt;
      invalid_r  <= invalid_nxt;
    end
  end

  assign Q       = q_r;
  assign Q_not   = ~q_r & ~both_low_r;
  assign invalid = invalid_r;

`ifdef SR_LATCH_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // One count per edge that registers any invalid bit, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= '0;
    end else if (|invalid_nxt && err_cnt_r != '1) begin
      err_cnt_r <= err_cnt_r + 1'b1;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_sr_latch.sv
// Testbench for sr_latch: four 1-bit instances (one per invalid policy) and a
// 4-bit, 2-stage-synchronised instance, checked against a behavioural model.
module tb_sr_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0, s1 = 1'b0, r1 = 1'b0;
  logic [3:0] s4 = '0, r4 = '0;

  logic [3:0] q1, qn1, inv1;
  logic [3:0] q4, qn4, inv4;
`ifdef SR_LATCH_ERR_CNT_EN
  logic [15:0] ec1 [4];
  logic [15:0] ec4;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: Q and Q_not are tracked directly as two observable bits.
  logic [3:0] mq1, mqn1, minv1;
  logic [3:0] mq4, mqn4, minv4;
  int         mcnt1 [4];
  int         mcnt4;
  logic [8:0] pipe [$];

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_pol
    sr_latch #(.WIDTH(1), .INVALID_POLICY(p), .SYNC_STAGES(0)) dut (
      .clk     (clk),
      .rst     (rst),
      .S       (s1),
      .R       (r1),
      .E       (e),
      .Q       (q1[p]),
      .Q_not   (qn1[p]),
      .invalid (inv1[p])
`ifdef SR_LATCH_ERR_CNT_EN
      ,
      .err_cnt (ec1[p])
`endif
    );
  end

  sr_latch #(.WIDTH(4), .INVALID_POLICY(0), .SYNC_STAGES(2)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .S       (s4),
    .R       (r4),
    .E       (e),
    .Q       (q4),
    .Q_not   (qn4),
    .invalid (inv4)
`ifdef SR_LATCH_ERR_CNT_EN
    ,
    .err_cnt (ec4)
`endif
  );

  // Returns {Q, Q_not, invalid} after one edge from the latch truth table.
  function automatic logic [2:0] nextBit(input logic q, qn, en, s, r, input int pol);
    if (!en || (!s && !r)) return (!q && !qn) ? 3'b010 : {q, qn, 1'b0};
    if (s && !r) return 3'b100;
    if (!s && r) return 3'b010;
    case (pol)
      0:       return 3'b001;
      1:       return 3'b101;
      2:       return 3'b011;
      default: return {q, qn, 1'b1};
    endcase
  endfunction

  task automatic modelReset();
    mq1 = '0; mqn1 = '1; minv1 = '0;
    mq4 = '0; mqn4 = '1; minv4 = '0;
    for (int p = 0; p < 4; p++) mcnt1[p] = 0;
    mcnt4 = 0;
    pipe = {9'd0, 9'd0};
  endtask

  task automatic modelEdge();
    logic [8:0] cur;
    logic [3:0] cs, cr;
    for (int p = 0; p < 4; p++) begin
      {mq1[p], mqn1[p], minv1[p]} = nextBit(mq1[p], mqn1[p], e, s1, r1, p);
      if (minv1[p] && mcnt1[p] < 65535) mcnt1[p]++;
    end
    pipe.push_back({e, s4, r4});
    cur = pipe.pop_front();
    cs = cur[7:4];
    cr = cur[3:0];
    for (int b = 0; b < 4; b++)
      {mq4[b], mqn4[b], minv4[b]} = nextBit(mq4[b], mqn4[b], cur[8], cs[b], cr[b], 0);
    if (|minv4 && mcnt4 < 65535) mcnt4++;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, " Q1"},     16'(q1),   16'(mq1));
    checkOutput({ctx, " Q_not1"}, 16'(qn1),  16'(mqn1));
    checkOutput({ctx, " inv1"},   16'(inv1), 16'(minv1));
    checkOutput({ctx, " Q4"},     16'(q4),   16'(mq4));
    checkOutput({ctx, " Q_not4"}, 16'(qn4),  16'(mqn4));
    checkOutput({ctx, " inv4"},   16'(inv4), 16'(minv4));
`ifdef SR_LATCH_ERR_CNT_EN
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("%s err_cnt1[%0d]", ctx, p), ec1[p], 16'(mcnt1[p]));
    checkOutput({ctx, " err_cnt4"}, ec4, 16'(mcnt4));
`endif
  endtask

  task automatic applyStimulus(input logic ei, si, ri, input logic [3:0] si4, ri4, input string ctx);
    e = ei; s1 = si; r1 = ri; s4 = si4; r4 = ri4;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(ctx);
  endtask

  // Raise reset between edges and check outputs clear before any clock edge.
  task automatic midReset(input string ctx);
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput({ctx, " async Q1"},     16'(q1),  16'h0000);
    checkOutput({ctx, " async Q_not1"}, 16'(qn1), 16'h000F);
    checkAll({ctx, " async"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    #2;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'hF, 4'h0, "gate S");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'h0, 4'hF, "gate R");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 4'hF, 4'hF, "gate SR");
    checkOutput("gate Q1", 16'(q1), 16'h0000);

    applyStimulus(1, 1, 0, 4'h0, 4'h0, "set");
    checkOutput("set Q1", 16'(q1), 16'h000F);
    midReset("mid");

    applyStimulus(1, 0, 1, 4'h0, 4'h0, "reset cmd");
    applyStimulus(1, 0, 0, 4'h0, 4'h0, "hold");
    applyStimulus(1, 1, 1, 4'h0, 4'h0, "invalid");
    checkOutput("invalid Q1",     16'(q1),   16'h0002);
    checkOutput("invalid Q_not1", 16'(qn1),  16'h000C);
    checkOutput("invalid inv1",   16'(inv1), 16'h000F);
    applyStimulus(1, 0, 0, 4'h0, 4'h0, "nor exit");
    checkOutput("nor exit Q_not1", 16'(qn1 & 4'h1), 16'h0001);

    midReset("w4");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 4'b1010, 4'b0110, "w4 mixed");
    checkOutput("w4 Q4",     16'(q4),   16'h0008);
    checkOutput("w4 Q_not4", 16'(qn4),  16'h0005);
    checkOutput("w4 inv4",   16'(inv4), 16'h0002);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 4'b1010, 4'b0110, "w4 persist");
`ifdef SR_LATCH_ERR_CNT_EN
    checkOutput("w4 err_cnt4 persist", ec4, 16'd3);
`endif

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                    4'($urandom), 4'($urandom), "random");
      if ($urandom_range(0, 49) == 0) midReset("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch.md
Name: sr_latch

Overview:
- Clocked, registered model of a gated (enable-qualified) SR latch with complementary outputs Q/Q_not.
- S/R/E are sampled on the rising clock edge. Q changes only while E is high.
- The forbidden S=R=1 combination resolves deterministically, selected by a parameter, and is flagged.
- Used as a control/status flag element in lab-level datapaths. Replaces a combinational cross-coupled NOR latch so timing is analysable.

Parameters:
- WIDTH, 1, number of independent latch bits. S, R, Q, Q_not and invalid are WIDTH wide; E is shared.
- INVALID_POLICY, 0, response per bit to enabled S=R=1:
  - 0 = NOR-style: Q=0, Q_not=0.
  - 1 = set-dominant.
  - 2 = reset-dominant.
  - 3 = hold.
- SYNC_STAGES, 0, number of flop stages on S/R/E before the latch register. Legal values are 0..3.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- S, input, WIDTH, set request per bit.
- R, input, WIDTH, reset request per bit.
- E, input, 1, enable (gate). Shared by all bits.
- Q, output, WIDTH, latch state.
- Q_not, output, WIDTH, complementary state. Equals ~Q except in NOR-style invalid.
- invalid, output, WIDTH, high for the cycle in which that bit's registered state came from an enabled S=R=1.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-sequence):
  - Q=0, Q_not=all ones, invalid=0.
  - Synchronizer stages cleared to 0.
  - Outputs hold these values until the first rising edge after rst deasserts.
- Latency: with SYNC_STAGES=0, inputs sampled at edge N appear on Q/Q_not/invalid after edge N. Each synchronizer stage adds one cycle.
- E=0: every bit holds Q and Q_not regardless of S/R. invalid=0.
- E=1, per bit:
  - S=0, R=0: hold.
  - S=0, R=1: Q=0, Q_not=1.
  - S=1, R=0: Q=1, Q_not=0.
  - S=1, R=1: apply INVALID_POLICY and set invalid=1 for that bit.
- NOR-style exit (policy 0): a bit holding Q=0, Q_not=0 that next sees hold (enabled 00, or E=0) resolves to the reset state Q=0, Q_not=1 on that edge. This resolution is the fixed replacement for a real latch race.
- invalid is not sticky. It clears on the next edge that does not sample an enabled S=R=1.
- Bits are fully independent. Mixed per-bit commands in one cycle are legal.
- The state register is a single WIDTH-wide Q register plus a WIDTH-wide "both-low" flag. Q_not is derived as ~Q & ~both_low.
- Illegal parameter values (INVALID_POLICY > 3, SYNC_STAGES > 3) must fail elaboration via a generate-time check.

Optional Feature:
- Macro: SR_LATCH_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (16 bits).
  - err_cnt increments by 1 on each edge where any bit's invalid becomes or stays high. Counts once per cycle, not per bit.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst.
- Undefined: err_cnt port and counter are absent. Core behaviour is identical.

Decomposition:
- Shared package sr_latch_pkg holds:
  - Policy constants POL_NOR=0, POL_SET=1, POL_RST=2, POL_HOLD=3.
  - Typedef sr_cmd_e: HOLD, RESET, SET, INVALID, decoded from {S,R}.
  - Constant ERR_CNT_W=16.
- One sub-module, sr_sync, is natural. It is the parameterised SYNC_STAGES-deep reset-clearable delay line for the S/R/E bundle. At depth 0 it is a pass-through.
- The next-state decode stays in the top module.

Test Plan:
- Reset: assert rst mid-run with Q=1 -> Q=0 and Q_not=1 immediately, without waiting for a clock edge; invalid=0.
- Enable gating: E=0, apply S=1/R=0, then S=0/R=1, then S=1/R=1, each for 3 cycles -> Q stays 0, Q_not stays 1, invalid stays 0 throughout.
- Set/reset, SYNC_STAGES=0:
  - E=1, S=1, R=0 -> Q=1, Q_not=0 after one edge.
  - Then S=0, R=1 -> Q=0, Q_not=1.
  - Then S=0, R=0 -> hold Q=0, Q_not=1.
- Invalid, INVALID_POLICY=0: E=1, S=1, R=1 -> Q=0, Q_not=0, invalid=1. Then S=0, R=0 -> Q=0, Q_not=1, invalid=0.
- Policies 1/2/3 with Q=0 preloaded, enabled S=R=1:
  - Policy 1 -> Q=1, Q_not=0.
  - Policy 2 -> Q=0, Q_not=1.
  - Policy 3 -> Q=0, Q_not=1.
  - invalid=1 in all three.
- WIDTH=4, SYNC_STAGES=2, err counter build:
  - E=1, S=4'b1010, R=4'b0110 -> after 3 edges Q=4'b1000, Q_not=4'b0101, invalid=4'b0010.
  - With SR_LATCH_ERR_CNT_EN defined, err_cnt increments by 1 per cycle while the invalid condition persists.
